// File: rtl/dds_button_conditioner.sv
// dds_button_conditioner: synchronise, debounce and pulse-shape the DDS
// up/down buttons and coarse/fine switch. Each button press yields a one-cycle
// step pulse; holding it auto-repeats. Pressing both at once locks out steps.
module dds_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned HOLD_CYCLES     = 62500000,
  parameter int unsigned REPEAT_CYCLES   = 12500000,
  parameter bit          IN_ACTIVE_LOW   = 1'b1,
  parameter bit          OUT_ACTIVE_LOW  = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_up_raw,
  input  logic i_btn_down_raw,
  input  logic i_sw_mode_raw,
  output logic o_aumentar,
  output logic o_disminuir,
  output logic o_tipo_ajuste,
  output logic o_lockout
);

  localparam int unsigned DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RCW     = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  // Lane 0 = up, 1 = down, 2 = mode switch. All lanes are active-high
  // "pressed/coarse" after this point; the switch is taken at face value.
  logic [2:0] raw_n;
  assign raw_n = {i_sw_mode_raw,
                  i_btn_down_raw ^ IN_ACTIVE_LOW,
                  i_btn_up_raw   ^ IN_ACTIVE_LOW};

  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     deb_q, deb_d;
  logic [DBW-1:0] dcnt_q [3];
  logic [DBW-1:0] dcnt_d [3];
  logic           mode_tog;

  state_t         st_q [2];
  state_t         st_d [2];
  logic [RCW-1:0] rc_q [2];
  logic [RCW-1:0] rc_d [2];
  logic [1:0]     pulse_d;
  logic           lock_q, lock_d;
  logic           both_pressed;
  logic           aum_q, dis_q;

  // Two-flop synchroniser; reset loads the released level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count cycles the synced level disagrees; flip after DEBOUNCE_CYCLES.
  always_comb begin
    deb_d    = deb_q;
    mode_tog = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = ~deb_q[i];
          if (i == 2) mode_tog = 1'b1;
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      deb_q <= '0;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  assign both_pressed = deb_q[0] & deb_q[1];
  // Lockout sets on a simultaneous press and holds until both are released.
  assign lock_d = both_pressed | (lock_q & (deb_q[0] | deb_q[1]));

  // Per-button press/hold/repeat FSM. Lockout and release dominate; a mode
  // toggle restarts the hold window so the new step size starts fresh.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_d[b]    = st_q[b];
      rc_d[b]    = rc_q[b];
      pulse_d[b] = 1'b0;
      if (both_pressed || lock_q || !deb_q[b]) begin
        st_d[b] = S_IDLE;
        rc_d[b] = '0;
      end else begin
        case (st_q[b])
          S_IDLE: begin
            pulse_d[b] = 1'b1;
            st_d[b]    = S_HOLD;
            rc_d[b]    = '0;
          end
          S_HOLD: begin
            if (mode_tog) begin
              rc_d[b] = '0;
            end else if (rc_q[b] == RCW'(HOLD_CYCLES - 1)) begin
              pulse_d[b] = 1'b1;
              st_d[b]    = S_REPEAT;
              rc_d[b]    = '0;
            end else begin
              rc_d[b] = rc_q[b] + 1'b1;
            end
          end
          S_REPEAT: begin
            if (mode_tog) begin
              st_d[b] = S_HOLD;
              rc_d[b] = '0;
            end else if (rc_q[b] == RCW'(REPEAT_CYCLES - 1)) begin
              pulse_d[b] = 1'b1;
              rc_d[b]    = '0;
            end else begin
              rc_d[b] = rc_q[b] + 1'b1;
            end
          end
          default: begin
            st_d[b] = S_IDLE;
            rc_d[b] = '0;
          end
        endcase
      end
    end
  end

  // FSM, lockout and registered output pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b] <= S_IDLE;
        rc_q[b] <= '0;
      end
      lock_q <= 1'b0;
      aum_q  <= OUT_ACTIVE_LOW;
      dis_q  <= OUT_ACTIVE_LOW;
    end else begin
      for (int b = 0; b < 2; b++) begin
        st_q[b] <= st_d[b];
        rc_q[b] <= rc_d[b];
      end
      lock_q <= lock_d;
      aum_q  <= pulse_d[0] ^ OUT_ACTIVE_LOW;
      dis_q  <= pulse_d[1] ^ OUT_ACTIVE_LOW;
    end
  end

  assign o_aumentar    = aum_q;
  assign o_disminuir   = dis_q;
  assign o_tipo_ajuste = deb_q[2];
  assign o_lockout     = lock_q;

endmodule

// File: tb/tb_dds_button_conditioner.sv
// Bench for dds_button_conditioner: directed scenarios plus random stimulus,
// all compared each cycle against an elapsed-time reference model.
module tb_dds_button_conditioner;
  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst_n, up_raw, dn_raw, sw_raw;
  logic o_aumentar, o_disminuir, o_tipo_ajuste, o_lockout;

  dds_button_conditioner #(
    .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R),
    .IN_ACTIVE_LOW(1'b1), .OUT_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_btn_up_raw(up_raw), .i_btn_down_raw(dn_raw), .i_sw_mode_raw(sw_raw),
    .o_aumentar(o_aumentar), .o_disminuir(o_disminuir),
    .o_tipo_ajuste(o_tipo_ajuste), .o_lockout(o_lockout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [3:0] obs;
  assign obs = {o_aumentar, o_disminuir, o_tipo_ajuste, o_lockout};

  // Reference model: levels settle after D agreeing-different synced samples;
  // a held button pulses at press, then at age H, H+R, H+2R ... where age
  // counts cycles since press or since the last mode change.
  bit [2:0]   m_s1, m_s2, m_deb;
  int         m_run [3];
  bit         m_lock;
  bit         m_act [2];
  int         m_age [2];
  logic [3:0] exp_v = 4'b1100;

  task automatic model_step;
    bit [2:0] inp;
    bit [1:0] pulse;
    bit       both, tog, lock_n;
    inp = {sw_raw, ~dn_raw, ~up_raw};
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_lock = 1'b0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      for (int b = 0; b < 2; b++) begin m_act[b] = 1'b0; m_age[b] = 0; end
      exp_v = 4'b1100;
    end else begin
      both  = m_deb[0] & m_deb[1];
      tog   = (m_s2[2] != m_deb[2]) && (m_run[2] + 1 == D);
      pulse = '0;
      for (int b = 0; b < 2; b++) begin
        if (both || m_lock || !m_deb[b]) m_act[b] = 1'b0;
        else if (!m_act[b]) begin
          pulse[b] = 1'b1; m_act[b] = 1'b1; m_age[b] = 0;
        end else if (tog) m_age[b] = 0;
        else begin
          m_age[b]++;
          if (m_age[b] >= H && (m_age[b] - H) % R == 0) pulse[b] = 1'b1;
        end
      end
      lock_n = both | (m_lock & (m_deb[0] | m_deb[1]));
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin m_deb[i] = m_s2[i]; m_run[i] = 0; end
        end else m_run[i] = 0;
      end
      m_s2 = m_s1; m_s1 = inp; m_lock = lock_n;
      exp_v = {~pulse[0], ~pulse[1], m_deb[2], m_lock};
    end
  endtask

  // Advance one clock, step the model, land on the falling edge for sampling.
  task automatic tick;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; up_raw = 1'b1; dn_raw = 1'b1; sw_raw = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== 4'b1100) begin errors++; $display("FAIL reset_vals got=%b exp=1100", obs); end
    rst_n = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      tick();
      checks++;
      if (obs !== exp_v || obs !== 4'b1100) begin
        errors++; $display("FAIL idle cyc=%0d got=%b model=%b exp=1100", cyc, obs, exp_v);
      end
    end
  endtask

  task automatic test_glitch;
    int n_p, p_t;
    n_p = 0; p_t = 0;
    up_raw = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      if (t == 4) up_raw = 1'b1;
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL glitch cyc=%0d got=%b model=%b", cyc, obs, exp_v); end
      if (o_aumentar === 1'b0) n_p++;
    end
    checks++;
    if (n_p != 0) begin errors++; $display("FAIL glitch_pulses got=%0d exp=0", n_p); end
    n_p = 0;
    up_raw = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      if (t == 11) up_raw = 1'b1;
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL press cyc=%0d got=%b model=%b", cyc, obs, exp_v); end
      if (o_aumentar === 1'b0) begin n_p++; p_t = t; end
    end
    checks++;
    if (n_p != 1 || p_t != 7) begin
      errors++; $display("FAIL press_pulse got n=%0d t=%0d exp n=1 t=7", n_p, p_t);
    end
  endtask

  task automatic test_hold_repeat;
    int exp_t [6] = '{7, 27, 35, 43, 51, 59};
    int idx;
    idx = 0;
    dn_raw = 1'b0;
    for (int t = 1; t <= 80; t++) begin
      if (t == 61) dn_raw = 1'b1;
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL repeat cyc=%0d got=%b model=%b", cyc, obs, exp_v); end
      if (o_aumentar === 1'b0) begin errors++; $display("FAIL repeat_up t=%0d got=0 exp=1", t); end
      if (o_disminuir === 1'b0 && t <= 60) begin
        checks++;
        if (idx >= 6 || t != exp_t[idx]) begin
          errors++; $display("FAIL repeat_time got=%0d exp=%0d", t, (idx < 6) ? exp_t[idx] : -1);
        end
        idx++;
      end
    end
    checks++;
    if (idx != 6) begin errors++; $display("FAIL repeat_count got=%0d exp=6", idx); end
  endtask

  task automatic test_lockout;
    bit saw_lock;
    int bad, n_p, p_t;
    saw_lock = 1'b0; bad = 0; n_p = 0; p_t = 0;
    up_raw = 1'b0;
    for (int t = 1; t <= 110; t++) begin
      if (t == 30) dn_raw = 1'b0;
      if (t == 50) dn_raw = 1'b1;
      if (t == 80) up_raw = 1'b1;
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL lockout cyc=%0d got=%b model=%b", cyc, obs, exp_v); end
      if (o_lockout === 1'b1) saw_lock = 1'b1;
      if (t >= 37 && (o_aumentar === 1'b0 || o_disminuir === 1'b0)) bad++;
    end
    checks++;
    if (!saw_lock || bad != 0 || o_lockout !== 1'b0) begin
      errors++; $display("FAIL lockout_seq got lock_seen=%0d pulses=%0d lock_end=%b exp 1 0 0", saw_lock, bad, o_lockout);
    end
    up_raw = 1'b0;
    for (int t = 1; t <= 25; t++) begin
      if (t == 12) up_raw = 1'b1;
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL repress cyc=%0d got=%b model=%b", cyc, obs, exp_v); end
      if (o_aumentar === 1'b0) begin n_p++; p_t = t; end
    end
    checks++;
    if (n_p != 1 || p_t != 7) begin errors++; $display("FAIL repress_pulse got n=%0d t=%0d exp n=1 t=7", n_p, p_t); end
  endtask

  task automatic test_mode_change;
    int t_mode, n_after, d1, d2;
    t_mode = -1; n_after = 0; d1 = -1; d2 = -1;
    up_raw = 1'b0;
    for (int t = 1; t <= 90; t++) begin
      if (t == 40) sw_raw = 1'b1;
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL mode cyc=%0d got=%b model=%b", cyc, obs, exp_v); end
      if (t_mode < 0 && o_tipo_ajuste === 1'b1) t_mode = t;
      else if (t_mode >= 0 && o_aumentar === 1'b0) begin
        n_after++;
        if (n_after == 1) d1 = t - t_mode;
        if (n_after == 2) d2 = t - t_mode;
      end
    end
    checks++;
    if (t_mode - 39 != 6) begin errors++; $display("FAIL mode_latency got=%0d exp=6", t_mode - 39); end
    checks++;
    if (d1 != 20 || d2 != 28) begin errors++; $display("FAIL mode_restart got=%0d,%0d exp=20,28", d1, d2); end
    up_raw = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL mode_rel cyc=%0d got=%b model=%b", cyc, obs, exp_v); end
    end
  endtask

  task automatic test_reset_mid;
    int n_p, p_t;
    n_p = 0; p_t = 0;
    up_raw = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL pre_rst cyc=%0d got=%b model=%b", cyc, obs, exp_v); end
    end
    rst_n = 1'b0; up_raw = 1'b1;
    tick();
    checks++;
    if (obs !== 4'b1100) begin errors++; $display("FAIL mid_reset got=%b exp=1100", obs); end
    rst_n = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL post_rst cyc=%0d got=%b model=%b", cyc, obs, exp_v); end
      if (o_aumentar === 1'b0) n_p++;
    end
    checks++;
    if (n_p != 0) begin errors++; $display("FAIL post_rst_pulses got=%0d exp=0", n_p); end
    up_raw = 1'b0;
    for (int t = 1; t <= 25; t++) begin
      if (t == 12) up_raw = 1'b1;
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rst_repress cyc=%0d got=%b model=%b", cyc, obs, exp_v); end
      if (o_aumentar === 1'b0) begin n_p++; p_t = t; end
    end
    checks++;
    if (n_p != 1 || p_t != 7) begin errors++; $display("FAIL rst_repress_pulse got n=%0d t=%0d exp n=1 t=7", n_p, p_t); end
  endtask

  task automatic test_random;
    for (int t = 0; t < 4000; t++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 23) == 0) up_raw = ~up_raw;
      if ($urandom_range(0, 27) == 0) dn_raw = ~dn_raw;
      if ($urandom_range(0, 59) == 0) sw_raw = ~sw_raw;
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random cyc=%0d got=%b model=%b", cyc, obs, exp_v); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_hold_repeat();
    test_lockout();
    test_mode_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
